// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   default register addresses, status-word bit positions, transmit FSM
//   state encoding and small helper functions.
//   Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_tx_periph_pkg;

    localparam logic [31:0] UART_TX_ADDR   = 32'h0000_0054;
    localparam logic [31:0] UART_STAT_ADDR = 32'h0000_0058;

    localparam int UART_BUSY_IDX  = 0;
    localparam int UART_EMPTY_IDX = 1;
    localparam int UART_FULL_IDX  = 2;
    localparam int UART_OVF_IDX   = 3;

    typedef enum logic [2:0] {
        UTX_IDLE  = 3'd0,
        UTX_START = 3'd1,
        UTX_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        UTX_PAR   = 3'd3,
`endif
        UTX_STOP  = 3'd4
    } utx_state_e;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Packs the status flags into the software-visible word; upper bits read 0.
    function automatic logic [31:0] status_word(input logic busy_v,
                                                input logic empty_v,
                                                input logic full_v,
                                                input logic ovf_v);
        logic [31:0] w;
        w                 = 32'h0000_0000;
        w[UART_BUSY_IDX]  = busy_v;
        w[UART_EMPTY_IDX] = empty_v;
        w[UART_FULL_IDX]  = full_v;
        w[UART_OVF_IDX]   = ovf_v;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, WIDTH bits wide and DEPTH entries deep (power of two,
//   at least 2). Pointers wrap naturally; the occupancy count is one bit wider
//   than the pointers so full and empty never alias. A push on a full FIFO is
//   accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din    write strobe and data
//   pop          read strobe (ignored while empty)
//   head         oldest entry, valid while !empty
//   full, empty  occupancy flags, registered-state derived
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == CNT_ZERO);
    assign head    = mem_r[rd_ptr_r];
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);

    // Storage array: holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph
//   Memory-mapped UART transmitter. Byte stores to TX_ADDR are queued in a
//   FIFO_DEPTH-entry FIFO and serialised LSB first on tx with one start and
//   one stop bit, CLK_DIV clocks per bit. A store to STAT_ADDR with data[0]=1
//   clears the sticky overflow flag.
//   Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
//   between the last data bit and the stop bit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   address    data-bus byte address
//   data       store data (low byte)
//   write      one-cycle store strobe
//   rd_data    status word {28'b0, overflow, full, empty, busy} at STAT_ADDR, else 0
//   tx         serial output, idle high
//   busy       FIFO non-empty or a frame in progress
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TX_ADDR    = UART_TX_ADDR,
    parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [7:0]  data,
    input  logic        write,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);
    localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'd7;

    logic        tx_wr_s;
    logic        stat_wr_s;
    logic        pop_s;
    logic [7:0]  head_s;
    logic        full_s;
    logic        empty_s;
    logic        busy_s;
    logic        baud_done_s;

    utx_state_e  state_r;
    utx_state_e  state_nxt_s;
    logic [15:0] baud_r;
    logic [15:0] baud_nxt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic        tx_r;
    logic        tx_nxt_s;
    logic        overflow_r;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
    logic        parity_nxt_s;
`endif

    assign tx_wr_s     = write && (address == TX_ADDR);
    assign stat_wr_s   = write && (address == STAT_ADDR);
    assign baud_done_s = (baud_r == 16'd0);
    assign busy_s      = !empty_s || (state_r != UTX_IDLE);

    assign busy    = busy_s;
    assign tx      = tx_r;
    assign rd_data = (address == STAT_ADDR) ?
                     status_word(busy_s, empty_s, full_s, overflow_r) : 32'h0000_0000;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr_s),
        .pop   (pop_s),
        .din   (data),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sticky overflow: a dropped push sets it, software clears it; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (tx_wr_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else if (stat_wr_s && data[0]) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Transmit FSM, baud counter, shift register and registered tx pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= UTX_IDLE;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_nxt_s;
`endif
        end
    end

    // Next-state logic; tx is computed from the next state so the pin is a flop.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        tx_nxt_s      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s  = parity_r;
`endif

        case (state_r)
            UTX_IDLE: begin
                // Only registered FIFO state is seen, so a fresh push waits one cycle.
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    shift_nxt_s   = head_s;
                    bit_idx_nxt_s = 3'd0;
                    baud_nxt_s    = BAUD_LOAD;
                    state_nxt_s   = UTX_START;
`ifdef UART_TX_PARITY_EN
                    parity_nxt_s  = even_parity(head_s);
`endif
                end else begin
                    state_nxt_s = UTX_IDLE;
                end
            end
            UTX_START: begin
                if (baud_done_s) begin
                    baud_nxt_s  = BAUD_LOAD;
                    state_nxt_s = UTX_DATA;
                end else begin
                    baud_nxt_s = baud_r - 16'd1;
                end
            end
            UTX_DATA: begin
                if (baud_done_s) begin
                    baud_nxt_s = BAUD_LOAD;
                    if (bit_idx_r == LAST_BIT) begin
                        bit_idx_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_nxt_s   = UTX_PAR;
`else
                        state_nxt_s   = UTX_STOP;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    baud_nxt_s = baud_r - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            UTX_PAR: begin
                if (baud_done_s) begin
                    baud_nxt_s  = BAUD_LOAD;
                    state_nxt_s = UTX_STOP;
                end else begin
                    baud_nxt_s = baud_r - 16'd1;
                end
            end
`endif
            UTX_STOP: begin
                if (baud_done_s) begin
                    baud_nxt_s  = 16'd0;
                    state_nxt_s = UTX_IDLE;
                end else begin
                    baud_nxt_s = baud_r - 16'd1;
                end
            end
            default: begin
                baud_nxt_s    = 16'd0;
                bit_idx_nxt_s = 3'd0;
                state_nxt_s   = UTX_IDLE;
            end
        endcase

        case (state_nxt_s)
            UTX_START: tx_nxt_s = 1'b0;
            UTX_DATA:  tx_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
            UTX_PAR:   tx_nxt_s = parity_nxt_s;
`endif
            default:   tx_nxt_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph
//   Self-checking bench for uart_tx_periph (CLK_DIV=4, FIFO_DEPTH=4).
//   A timeline model predicts for every store whether it is accepted and on
//   which cycle its start bit appears; accepted bytes go into a scoreboard
//   queue that an independent line monitor pops and compares frame by frame.
//   Honours UART_TX_PARITY_EN for 11-bit frames.
module tb_uart_tx_periph;
    localparam int          CLK_DIV = 4;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] TX_A    = 32'h0000_0054;
    localparam logic [31:0] ST_A    = 32'h0000_0058;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC = FRAME_BITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [31:0] address;
    logic [7:0]  data;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t sb_q[$];
    int   hist_push[$];
    int   hist_start[$];
    int   last_start = -1000;
    logic ovf_m      = 1'b0;

    uart_tx_periph #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .TX_ADDR    (TX_A),
        .STAT_ADDR  (ST_A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .data    (data),
        .write   (write),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k during the cycle that follows the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bytes in the FIFO during cycle c: pushed before c, not yet popped (pop = start-1).
    function automatic int occ_at(input int c);
        int n = 0;
        foreach (hist_push[i]) if (hist_push[i] < c && hist_start[i] - 1 >= c) n++;
        return n;
    endfunction

    function automatic logic busy_at(input int c);
        logic r = (occ_at(c) > 0);
        foreach (hist_start[i]) if (c >= hist_start[i] && c < hist_start[i] + FRAME_CYC) r = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] stat_at(input int c);
        int o = occ_at(c);
        return {28'h0, ovf_m, (o == DEPTH), (o == 0), busy_at(c)};
    endfunction

    // Line level of bit k of a frame: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_push(input int t, input logic [7:0] d);
        logic popping = 1'b0;
        int   s;
        foreach (hist_start[i]) if (hist_start[i] - 1 == t) popping = 1'b1;
        if (occ_at(t) < DEPTH || popping) begin
            s = (t + 2 > last_start + FRAME_CYC + 1) ? t + 2 : last_start + FRAME_CYC + 1;
            hist_push.push_back(t);
            hist_start.push_back(s);
            last_start = s;
            sb_q.push_back('{b: d, start: s});
        end else begin
            ovf_m = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        address = a;
        data    = d;
        write   = 1'b1;
        if (a == TX_A) model_push(cyc, d);
        else if (a == ST_A && d[0]) ovf_m = 1'b0;
        @(posedge clk); #1;
        write   = 1'b0;
        address = 32'h0;
        data    = 8'h00;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_stat(input string name, output logic [31:0] v);
        address = ST_A;
        #1;
        v = rd_data;
        check(name, rd_data, stat_at(cyc));
        @(posedge clk); #1;
        address = 32'h0;
    endtask

    task automatic drain();
        wait_until(last_start + FRAME_CYC + 1);
        check("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Line monitor: finds start bits, pops the scoreboard and checks every cycle of the frame.
    initial begin : monitor
        bit         active = 1'b0;
        bit         have   = 1'b0;
        logic       prev   = 1'b1;
        int         st     = 0;
        int         errs   = 0;
        int         k;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                prev   = 1'b1;
            end else begin
                if (!active && prev && !tx) begin
                    active = 1'b1;
                    st     = cyc;
                    errs   = 0;
                    check("frame_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e    = sb_q.pop_front();
                        have = 1'b1;
                        check("start_cycle", st, e.start);
                    end else begin
                        have = 1'b0;
                    end
                end
                if (active) begin
                    k = (cyc - st) / CLK_DIV;
                    if (have && tx !== exp_bit(e.b, k)) errs++;
                    if (cyc - st == FRAME_CYC - 1) begin
                        if (have) check("frame_bits", errs, 32'd0);
                        active = 1'b0;
                    end
                end
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int          t0;
        int          s;
        int          g;
        int          zeros;
        logic [31:0] v;

        rst = 1'b1; write = 1'b0; address = 32'h0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle state.
        repeat (20) @(posedge clk);
        #1;
        check1("reset_tx", tx, 1'b1);
        check1("reset_busy", busy, 1'b0);
        address = ST_A; #1;
        check("reset_stat", rd_data, 32'h0000_0002);
        address = TX_A; #1;
        check("rd_other_addr", rd_data, 32'h0000_0000);
        address = 32'h0;
        @(posedge clk); #1;

        // Single frame 0xA5: latency, stop bit and busy fall.
        t0 = cyc;
        do_write(TX_A, 8'hA5);
        check1("latency_c1_tx_high", tx, 1'b1);
        wait_until(t0 + 2);  check1("latency_c2_tx_low", tx, 1'b0);
        wait_until(t0 + 41); check1("stop_c41_tx", tx, 1'b1);
        check1("busy_c41", busy, 1'b1);
        wait_until(t0 + 42); check1("busy_c42", busy, 1'b0);

        // Back-to-back frames: one idle cycle between them.
        t0 = cyc;
        do_write(TX_A, 8'h01);
        do_write(TX_A, 8'h02);
        wait_until(t0 + 42); check1("b2b_gap_tx", tx, 1'b1);
        wait_until(t0 + 43); check1("b2b_second_start", tx, 1'b0);
        drain();

        // Overflow: six stores while idle, the last one is dropped.
        for (int i = 0; i < 6; i++) do_write(TX_A, 8'(8'h10 + i));
        chk_stat("ovf_stat_word", v);
        check1("ovf_flag_set", v[3], 1'b1);
        check1("ovf_full_set", v[2], 1'b1);
        do_write(ST_A, 8'h01);
        chk_stat("ovf_clear_word", v);
        check1("ovf_flag_cleared", v[3], 1'b0);
        drain();

        // Randomised stores with random gaps, occasional status reads and clears.
        for (int n = 0; n < 40; n++) begin
            g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            repeat (g) @(posedge clk);
            #1;
            do_write(TX_A, 8'($urandom));
            if ($urandom_range(0, 4) == 0) chk_stat("rand_stat", v);
            if ($urandom_range(0, 9) == 0) do_write(ST_A, 8'($urandom_range(0, 1)));
        end
        drain();

        // Reset during the third data bit of a frame with bytes still queued.
        t0 = cyc;
        do_write(TX_A, 8'h3C);
        do_write(TX_A, 8'hC3);
        do_write(TX_A, 8'h5A);
        s = t0 + 2;
        wait_until(s + 13);
        rst = 1'b1;
        sb_q.delete(); hist_push.delete(); hist_start.delete();
        last_start = -1000; ovf_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("rst_mid_tx", tx, 1'b1);
        check1("rst_mid_busy", busy, 1'b0);
        chk_stat("rst_mid_stat", v);
        zeros = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (!tx) zeros++;
        end
        check("rst_no_more_frames", zeros, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07: parity 1 after bit 7, stop, 45-cycle period.
        t0 = cyc;
        do_write(TX_A, 8'h07);
        s = t0 + 2;
        wait_until(s + 33); check1("par_bit7_zero", tx, 1'b0);
        wait_until(s + 37); check1("par_bit_one", tx, 1'b1);
        wait_until(s + 41); check1("par_stop", tx, 1'b1);
        wait_until(s + 43); check1("par_busy_last", busy, 1'b1);
        wait_until(s + 44); check1("par_busy_fall", busy, 1'b0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
